// File: rtl/hazard_controller_pkg.sv
// hazard_controller_pkg: shared state encoding and pipeline constants for the hazard controller
package hazard_controller_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_MC_WAIT = 1'b1} state_t;
  localparam int REG_AW_DEF = 5;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  // count qualifying cycles, holding at the maximum value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stage enables, flushes and bubbles for load-use, branch, mul/div and dmem-wait hazards
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int CNT_W      = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic              ex_mc_op,
  input  logic              mc_done,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              exmem_write,
  output logic              memwb_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_bubble,
  output logic              mc_start,
  output logic              mc_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  localparam int CW = $clog2(MC_TIMEOUT) + 1;
  state_t st, st_d;
  logic mc_done_q, done_q_d, bub_q, bub_d, err_d, mem_stall, load_use, done;
  logic [CW-1:0] mc_cnt, cnt_d;
  assign mem_stall = mem_req & ~mem_ready;
  assign done = mc_done | mc_done_q;
  assign load_use = ex_mem_read && ex_rd != '0 &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  // state, sticky done, wait counter, one-shot bubble flag and error flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st        <= ST_RUN;
      mc_done_q <= 1'b0;
      mc_cnt    <= '0;
      bub_q     <= 1'b0;
      mc_err    <= 1'b0;
    end else begin
      st        <= st_d;
      mc_done_q <= done_q_d;
      mc_cnt    <= cnt_d;
      bub_q     <= bub_d;
      mc_err    <= err_d;
    end
  // next state and all pipeline controls from current state and hazard inputs
  always_comb begin
    {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = 5'b11111;
    {ifid_flush, idex_flush, exmem_bubble, mc_start} = 4'b0000;
    st_d     = st;
    done_q_d = mc_done_q;
    cnt_d    = mc_cnt;
    bub_d    = bub_q;
    err_d    = mc_err;
    if (!rst_n) begin
      {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = 5'b00000;
    end else if (mem_stall) begin
      {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = 5'b00000;
      done_q_d = (st == ST_MC_WAIT) ? done : mc_done_q;
    end else if (st == ST_RUN) begin
      if (ex_mc_op) begin
        mc_start = 1'b1;
        {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
        st_d     = ST_MC_WAIT;
        cnt_d    = '0;
        bub_d    = 1'b0;
        done_q_d = 1'b0;
      end else if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end else if (done) begin
      st_d     = ST_RUN;
      done_q_d = 1'b0;
      cnt_d    = '0;
    end else if (mc_cnt == CW'(MC_TIMEOUT - 1)) begin
      err_d        = 1'b1;
      exmem_bubble = 1'b1;
      idex_flush   = 1'b1;
      st_d         = ST_RUN;
      cnt_d        = '0;
    end else begin
      {pc_write, ifid_write, idex_write} = 3'b000;
      exmem_write  = ~bub_q;
      exmem_bubble = ~bub_q;
      bub_d        = 1'b1;
      cnt_d        = mc_cnt + 1'b1;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(rst_n & ~pc_write), .count(stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(ifid_flush), .count(flush_cnt));
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed hazard scenarios with hand-computed expected controls and counters
module tb_hazard_controller;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, ex_mc_op, mc_done, mem_req, mem_ready;
  logic pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic ifid_flush, idex_flush, exmem_bubble, mc_start, mc_err;
  logic [31:0] stall_cnt, flush_cnt;
  logic pc_write8, ifid_write8, idex_write8, exmem_write8, memwb_write8;
  logic ifid_flush8, idex_flush8, exmem_bubble8, mc_start8, mc_err8;
  logic [3:0] stall_cnt8, flush_cnt8;
  logic [4:0] w, w8;
  logic [3:0] f, f8;
  int cmps = 0, errs = 0;

  assign w  = {pc_write, ifid_write, idex_write, exmem_write, memwb_write};
  assign f  = {ifid_flush, idex_flush, exmem_bubble, mc_start};
  assign w8 = {pc_write8, ifid_write8, idex_write8, exmem_write8, memwb_write8};
  assign f8 = {ifid_flush8, idex_flush8, exmem_bubble8, mc_start8};

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_mc_op(ex_mc_op), .mc_done(mc_done), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write), .exmem_write(exmem_write),
    .memwb_write(memwb_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_bubble(exmem_bubble), .mc_start(mc_start), .mc_err(mc_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  hazard_controller #(.CNT_W(4), .MC_TIMEOUT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_mc_op(ex_mc_op), .mc_done(mc_done), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write8), .ifid_write(ifid_write8), .idex_write(idex_write8), .exmem_write(exmem_write8),
    .memwb_write(memwb_write8), .ifid_flush(ifid_flush8), .idex_flush(idex_flush8),
    .exmem_bubble(exmem_bubble8), .mc_start(mc_start8), .mc_err(mc_err8),
    .stall_cnt(stall_cnt8), .flush_cnt(flush_cnt8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, ex_mc_op, mc_done, mem_req, mem_ready} = '0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_writes", 32'(w), 32'h0);
    chk("rst_flags", 32'(f), 32'h0);
    chk("rst_cnt", stall_cnt | flush_cnt, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    #1;
    chk("por_writes", 32'(w), 32'h0);
    chk("por_err", 32'({mc_err, mc_err8}), 32'h0);
    do_reset();
    step(); #1;
    chk("idle_writes", 32'(w), 32'h1f);
    chk("idle_flags", 32'(f), 32'h0);
    // load-use on rs1
    step(); ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; #1;
    chk("lu_rs1_writes", 32'(w), 32'h07);
    chk("lu_rs1_flags", 32'(f), 32'h4);
    step(); #1;
    chk("lu_after_writes", 32'(w), 32'h1f);
    chk("lu_stall_cnt", stall_cnt, 32'd1);
    // load-use on rs2, then rs2 match without use
    step(); ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; #1;
    chk("lu_rs2_writes", 32'(w), 32'h07);
    step(); ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; #1;
    chk("lu_nouse_writes", 32'(w), 32'h1f);
    // load to x0 never stalls
    step(); ex_mem_read = 1; id_use_rs1 = 1; #1;
    chk("lu_x0_writes", 32'(w), 32'h1f);
    chk("lu_x0_flags", 32'(f), 32'h0);
    // branch beats load-use
    step(); ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1; #1;
    chk("br_writes", 32'(w), 32'h1f);
    chk("br_flags", 32'(f), 32'hc);
    step(); #1;
    chk("br_flush_cnt", flush_cnt, 32'd1);
    chk("br_stall_cnt", stall_cnt, 32'd2);
    // DIV, done after 10 waiting cycles
    do_reset();
    step(); ex_mc_op = 1; #1;
    chk("div_start_writes", 32'(w), 32'h01);
    chk("div_start_flags", 32'(f), 32'h1);
    step(); #1;
    chk("div_bubble_writes", 32'(w), 32'h03);
    chk("div_bubble_flags", 32'(f), 32'h2);
    for (int i = 2; i <= 10; i++) begin
      step(); #1;
      chk("div_wait_writes", 32'(w), 32'h01);
      chk("div_wait_flags", 32'(f), 32'h0);
    end
    step(); mc_done = 1; #1;
    chk("div_done_writes", 32'(w), 32'h1f);
    chk("div_done_flags", 32'(f), 32'h0);
    step(); #1;
    chk("div_run_writes", 32'(w), 32'h1f);
    chk("div_stall_cnt", stall_cnt, 32'd11);
    chk("div_no_err", 32'(mc_err), 32'h0);
    // DIV with done arriving during a dmem stall
    do_reset();
    step(); ex_mc_op = 1; #1;
    chk("ms_start", 32'(f), 32'h1);
    step(); #1;
    chk("ms_bubble", 32'(f), 32'h2);
    step(); mem_req = 1; mc_done = 1; #1;
    chk("ms_stall0_writes", 32'(w), 32'h0);
    chk("ms_stall0_flags", 32'(f), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(); mem_req = 1; #1;
      chk("ms_stall_writes", 32'(w), 32'h0);
    end
    step(); mem_req = 1; mem_ready = 1; #1;
    chk("ms_done_writes", 32'(w), 32'h1f);
    chk("ms_done_flags", 32'(f), 32'h0);
    step(); #1;
    chk("ms_run_writes", 32'(w), 32'h1f);
    chk("ms_stall_cnt", stall_cnt, 32'd5);
    // reset in the middle of a wait returns to RUN with no start pulse
    step(); ex_mc_op = 1; #1;
    chk("mid_start", 32'(f), 32'h1);
    step(); #1;
    do_reset();
    step(); #1;
    chk("mid_rst_writes", 32'(w), 32'h1f);
    chk("mid_rst_flags", 32'(f), 32'h0);
    // timeout with MC_TIMEOUT=8
    do_reset();
    step(); ex_mc_op = 1; #1;
    chk("to_start", 32'(f8), 32'h1);
    step(); #1;
    chk("to_bubble_writes", 32'(w8), 32'h03);
    for (int i = 2; i <= 7; i++) begin
      step(); #1;
      chk("to_wait_writes", 32'(w8), 32'h01);
      chk("to_wait_err", 32'(mc_err8), 32'h0);
    end
    step(); #1;
    chk("to_exp_writes", 32'(w8), 32'h1f);
    chk("to_exp_flags", 32'(f8), 32'h6);
    step(); #1;
    chk("to_err", 32'(mc_err8), 32'h1);
    chk("to_run_writes", 32'(w8), 32'h1f);
    chk("to_stall_cnt", 32'(stall_cnt8), 32'd8);
    chk("to_flush_cnt", 32'(flush_cnt8), 32'd0);
    step(); ex_mc_op = 1; #1;
    chk("to_restart", 32'(f8), 32'h1);
    do_reset();
    chk("to_rst_err", 32'(mc_err8), 32'h0);
    chk("to_rst_cnt", 32'(stall_cnt8), 32'h0);
    // saturation of the 4-bit stall counter under a long dmem stall
    for (int i = 0; i < 20; i++) begin
      step(); mem_req = 1;
    end
    step(); #1;
    chk("sat_stall_cnt", 32'(stall_cnt8), 32'hf);
    chk("sat_stall_cnt32", stall_cnt, 32'd20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
